// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master native-bus arbiter.
// Optional timeout support is enabled with MEM_ARB_TIMEOUT_EN.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    typedef logic master_id_t;

    localparam master_id_t M0 = 1'b0;
    localparam master_id_t M1 = 1'b1;

    localparam logic [31:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_timeout.sv
// Slave no-response watchdog for the arbiter.
// Only instantiated when MEM_ARB_TIMEOUT_EN is defined.
module mem_arb_timeout #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1024
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic s_ready,
    output logic expired
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Count stalled cycles of the current transfer; zero outside a grant.
    always_comb begin
        cnt_d = '0;
        if (active && !s_ready) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = active && !s_ready && (cnt_q == TIMEOUT_CYCLES - 32'd1);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin two-master arbiter for the PicoRV32 native memory bus.
// Define MEM_ARB_TIMEOUT_EN to add the slave no-response timeout.
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int          ADDR_W         = 32,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_valid,
    input  logic              m0_instr,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    input  logic [3:0]        m0_wstrb,
    output logic              m0_ready,
    output logic [31:0]       m0_rdata,
    input  logic              m1_valid,
    input  logic              m1_instr,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    input  logic [3:0]        m1_wstrb,
    output logic              m1_ready,
    output logic [31:0]       m1_rdata,
    output logic              s_valid,
    output logic              s_instr,
    output logic [ADDR_W-1:0] s_addr,
    output logic [31:0]       s_wdata,
    output logic [3:0]        s_wstrb,
    input  logic              s_ready,
    input  logic [31:0]       s_rdata,
    output logic [1:0]        grant,
    output logic              arb_err
);

    arb_state_t state_q, state_d;
    master_id_t last_q, last_d;
    logic       timeout_hit;
    logic [31:0] rsp_data;

`ifdef MEM_ARB_TIMEOUT_EN
    logic arb_err_q, arb_err_d;

    mem_arb_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .active (s_valid),
        .s_ready(s_ready),
        .expired(timeout_hit)
    );

    // Timeout flag stays set until reset.
    always_comb begin
        arb_err_d = arb_err_q | timeout_hit;
    end

    // Sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            arb_err_q <= 1'b0;
        end else begin
            arb_err_q <= arb_err_d;
        end
    end

    assign arb_err = arb_err_q;
`else
    logic unused_cfg;
    assign unused_cfg  = ^TIMEOUT_CYCLES;
    assign timeout_hit = 1'b0;
    assign arb_err     = 1'b0;
`endif

    assign rsp_data = timeout_hit ? TIMEOUT_RDATA : s_rdata;

    // Next-state, round-robin choice and granted-master output mux.
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        s_valid  = 1'b0;
        s_instr  = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_wstrb  = '0;
        m0_ready = 1'b0;
        m0_rdata = '0;
        m1_ready = 1'b0;
        m1_rdata = '0;
        grant    = 2'b00;
        unique case (state_q)
            IDLE: begin
                if (m0_valid && m1_valid) begin
                    state_d = (last_q == M1) ? GNT0 : GNT1;
                end else if (m0_valid) begin
                    state_d = GNT0;
                end else if (m1_valid) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                grant    = 2'b01;
                s_valid  = m0_valid;
                s_instr  = m0_instr;
                s_addr   = m0_addr;
                s_wdata  = m0_wdata;
                s_wstrb  = m0_wstrb;
                m0_ready = s_ready | timeout_hit;
                m0_rdata = rsp_data;
                if (s_ready || timeout_hit) begin
                    state_d = IDLE;
                    last_d  = M0;
                end else if (!m0_valid) begin
                    state_d = IDLE;
                end
            end
            GNT1: begin
                grant    = 2'b10;
                s_valid  = m1_valid;
                s_instr  = m1_instr;
                s_addr   = m1_addr;
                s_wdata  = m1_wdata;
                s_wstrb  = m1_wstrb;
                m1_ready = s_ready | timeout_hit;
                m1_rdata = rsp_data;
                if (s_ready || timeout_hit) begin
                    state_d = IDLE;
                    last_d  = M1;
                end else if (!m1_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and last-winner registers; M0 wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= M1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

endmodule
